// File: rtl/alu_exec_if.sv
// Request, register-load, ALU and observation signals for alu_exec_ctrl.
// A request is accepted on the rising edge where req_valid && req_ready are both high.
// req_valid seen while req_ready is low is dropped and is not queued.
interface alu_exec_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [2:0]        req_src;
  logic [DATA_W-1:0] req_imm;
  logic              ld_valid;
  logic [2:0]        ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic [OP_W-1:0]   ALU_Select;
  logic [DATA_W-1:0] ALU_A;
  logic [DATA_W-1:0] ALU_B;
  logic [DATA_W-1:0] ALU_Out;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] flags;
  logic              done;

  modport master (
    output req_valid, req_op, req_src, req_imm, ld_valid, ld_idx, ld_data, ALU_Out,
    input  req_ready, ALU_Select, ALU_A, ALU_B, acc, flags, done
  );

  modport slave (
    input  req_valid, req_op, req_src, req_imm, ld_valid, ld_idx, ld_data, ALU_Out,
    output req_ready, ALU_Select, ALU_A, ALU_B, acc, flags, done
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Sequencer around an 8-bit combinational ALU: Z80-style register file,
// registered ALU operands and select, Z80 flag generation and A writeback.
module alu_exec_ctrl #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus,
  output logic [1:0] state_dbg
);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(5);
  localparam logic [2:0]      IDX_A   = 3'b111;
  localparam logic [2:0]      IDX_IMM = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] regs [8];
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   alu_sel_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, f_q, f_next, src_val, res;
  logic              accept, wr_a, wr_f;
  logic              h, pv, n, c;

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.done      = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = DONE;
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    src_val = (bus.req_src == IDX_IMM) ? bus.req_imm : regs[bus.req_src];
  end

  // Flags use the held operands and the original op (CMP shares the SUB select).
  always_comb begin
    res  = bus.ALU_Out;
    h    = 1'b0;
    pv   = 1'b0;
    n    = 1'b0;
    c    = 1'b0;
    wr_a = 1'b0;
    wr_f = 1'b0;
    case (op_q)
      OP_ADD: begin
        h    = ({1'b0, alu_a_q[3:0]} + {1'b0, alu_b_q[3:0]}) > 5'd15;
        pv   = (alu_a_q[DATA_W-1] == alu_b_q[DATA_W-1]) && (res[DATA_W-1] != alu_a_q[DATA_W-1]);
        c    = ({1'b0, alu_a_q} + {1'b0, alu_b_q}) > {1'b0, {DATA_W{1'b1}}};
        wr_a = 1'b1;
        wr_f = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        h    = alu_a_q[3:0] < alu_b_q[3:0];
        pv   = (alu_a_q[DATA_W-1] != alu_b_q[DATA_W-1]) && (res[DATA_W-1] != alu_a_q[DATA_W-1]);
        c    = alu_a_q < alu_b_q;
        n    = 1'b1;
        wr_a = (op_q == OP_SUB);
        wr_f = 1'b1;
      end
      OP_AND: begin
        h    = 1'b1;
        pv   = ~^res;
        wr_a = 1'b1;
        wr_f = 1'b1;
      end
      OP_OR, OP_XOR: begin
        pv   = ~^res;
        wr_a = 1'b1;
        wr_f = 1'b1;
      end
      default: ;
    endcase
    f_next = {res[DATA_W-1], (res == '0), 1'b0, h, 1'b0, pv, n, c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      f_q       <= '0;
      op_q      <= '0;
      alu_sel_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= bus.req_op;
        alu_sel_q <= (bus.req_op == OP_CMP) ? OP_SUB : bus.req_op;
        alu_a_q   <= regs[IDX_A];
        alu_b_q   <= src_val;
      end
      if (bus.ld_valid && bus.ld_idx != IDX_IMM) regs[bus.ld_idx] <= bus.ld_data;
      // Placed after the load so an A writeback beats a same-cycle load of A.
      if (state == EXEC) begin
        if (wr_a) regs[IDX_A] <= res;
        if (wr_f) f_q <= f_next;
      end
    end
  end

  assign bus.ALU_Select = alu_sel_q;
  assign bus.ALU_A      = alu_a_q;
  assign bus.ALU_B      = alu_b_q;
  assign bus.acc        = regs[IDX_A];
  assign bus.flags      = f_q;
  assign state_dbg      = state;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: table-driven ALU ops plus hand-built corner sequences,
// with expected {acc, flags} queued when a request is driven and popped on done.
module tb_alu_exec_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exec_if bus ();

  alu_exec_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Stand-in for the downstream combinational ALU.
  always_comb begin
    case (bus.ALU_Select)
      4'd0:    bus.ALU_Out = bus.ALU_A + bus.ALU_B;
      4'd1:    bus.ALU_Out = bus.ALU_A - bus.ALU_B;
      4'd2:    bus.ALU_Out = bus.ALU_A & bus.ALU_B;
      4'd3:    bus.ALU_Out = bus.ALU_A | bus.ALU_B;
      4'd4:    bus.ALU_Out = bus.ALU_A ^ bus.ALU_B;
      default: bus.ALU_Out = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [2:0] src;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] exp_acc;
    logic [7:0] exp_flags;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [15:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected done acc=%h flags=%h", name, bus.acc, bus.flags);
    end else begin
      exp = exp_q.pop_front();
      check(name, {bus.acc, bus.flags}, exp);
    end
  endtask

  task automatic load(input logic [2:0] idx, input logic [7:0] data);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_idx   = idx;
    bus.ld_data  = data;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  // ld_phase 0: load coincides with acceptance; 1: load coincides with writeback edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [2:0] src,
                       input logic [7:0] imm, input logic [7:0] exp_acc, input logic [7:0] exp_flags,
                       input bit do_ld, input bit ld_phase, input logic [2:0] ld_i, input logic [7:0] ld_d);
    int cyc;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src   = src;
    bus.req_imm   = imm;
    if (do_ld && !ld_phase) begin
      bus.ld_valid = 1'b1; bus.ld_idx = ld_i; bus.ld_data = ld_d;
    end
    exp_q.push_back({exp_acc, exp_flags});
    check({name, "_ready_idle"}, 16'(bus.req_ready), 16'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    check({name, "_ready_exec"}, 16'(bus.req_ready), 16'd0);
    if (do_ld && ld_phase) begin
      bus.ld_valid = 1'b1; bus.ld_idx = ld_i; bus.ld_data = ld_d;
    end
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      bus.ld_valid = 1'b0;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    check({name, "_latency"}, 16'(cyc), 16'd2);
    if (bus.done === 1'b1) sb_pop({name, "_result"});
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    logic [6:0] rdy_v, dn_v;
    bit saw_done;

    vecs[0]  = '{8'h7F, 3'd0, 8'h01, 4'd0, 8'h80, 8'h94};
    vecs[1]  = '{8'h00, 3'd6, 8'h01, 4'd1, 8'hFF, 8'h93};
    vecs[2]  = '{8'h10, 3'd6, 8'h10, 4'd5, 8'h10, 8'h42};
    vecs[3]  = '{8'hF0, 3'd6, 8'h3C, 4'd2, 8'h30, 8'h14};
    vecs[4]  = '{8'h30, 3'd7, 8'h30, 4'd4, 8'h00, 8'h44};
    vecs[5]  = '{8'h0F, 3'd1, 8'hF0, 4'd3, 8'hFF, 8'h84};
    vecs[6]  = '{8'hFF, 3'd6, 8'h01, 4'd0, 8'h00, 8'h51};
    vecs[7]  = '{8'h80, 3'd2, 8'h01, 4'd1, 8'h7F, 8'h16};
    vecs[8]  = '{8'h05, 3'd3, 8'h09, 4'd5, 8'h05, 8'h93};
    vecs[9]  = '{8'h07, 3'd4, 8'h01, 4'd4, 8'h06, 8'h04};
    vecs[10] = '{8'h07, 3'd5, 8'h01, 4'd2, 8'h01, 8'h10};
    vecs[11] = '{8'h80, 3'd0, 8'h80, 4'd0, 8'h00, 8'h45};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_src = '0; bus.req_imm = '0;
    bus.ld_valid = 1'b0; bus.ld_idx = '0; bus.ld_data = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 16'(state_dbg), 16'd0);
    check("rst_acc_flags", {bus.acc, bus.flags}, 16'h0000);
    check("rst_alu_ab", {bus.ALU_A, bus.ALU_B}, 16'h0000);
    check("rst_alu_sel", 16'(bus.ALU_Select), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_ready", 16'(bus.req_ready), 16'd1);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      load(3'd7, vecs[i].a);
      if (vecs[i].src < 3'd6) load(vecs[i].src, vecs[i].b);
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].src, vecs[i].b,
            vecs[i].exp_acc, vecs[i].exp_flags, 1'b0, 1'b0, 3'd0, 8'h00);
      check($sformatf("vec%0d_hold_ab", i), {bus.ALU_A, bus.ALU_B}, {vecs[i].a, vecs[i].b});
      check($sformatf("vec%0d_hold_sel", i), 16'(bus.ALU_Select),
            (vecs[i].op == 4'd5) ? 16'd1 : 16'(vecs[i].op));
    end

    // Operands come from the pre-load register value; the load itself still lands.
    load(3'd7, 8'h10);
    load(3'd0, 8'h01);
    issue("samp1", 4'd0, 3'd0, 8'h00, 8'h11, 8'h00, 1'b1, 1'b0, 3'd0, 8'hF0);
    issue("samp2", 4'd0, 3'd0, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00);

    // Same-cycle load of A loses to the ADD writeback.
    load(3'd7, 8'h7F);
    load(3'd0, 8'h01);
    issue("wb_wins", 4'd0, 3'd0, 8'h00, 8'h80, 8'h94, 1'b1, 1'b1, 3'd7, 8'h55);

    // Illegal op leaves A and F alone but still completes.
    load(3'd7, 8'h10);
    issue("cmp_pre", 4'd5, 3'd6, 8'h10, 8'h10, 8'h42, 1'b0, 1'b0, 3'd0, 8'h00);
    load(3'd7, 8'h22);
    issue("illegal", 4'd9, 3'd6, 8'h01, 8'h22, 8'h42, 1'b0, 1'b0, 3'd0, 8'h00);
    load(3'd6, 8'h99);
    check("ld_idx6_noop", {bus.acc, bus.flags}, 16'h2242);

    // req_valid held high: one accept per 3 cycles, requests during EXEC/DONE dropped.
    load(3'd7, 8'h01);
    load(3'd0, 8'h01);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_src = 3'd0;
    exp_q.push_back({8'h02, 8'h00});
    rdy_v = '0; dn_v = '0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      rdy_v[k] = bus.req_ready;
      dn_v[k]  = bus.done;
      if (bus.done === 1'b1) sb_pop($sformatf("b2b_result_k%0d", k));
      if (k == 3) exp_q.push_back({8'h03, 8'h00});
      if (k == 4) bus.req_valid = 1'b0;
    end
    check("b2b_ready_pattern", 16'(rdy_v), 16'(7'b1001001));
    check("b2b_done_pattern", 16'(dn_v), 16'(7'b0100100));

    // Reset during EXEC aborts the ADD with no done pulse.
    load(3'd7, 8'h05);
    load(3'd0, 8'h03);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_src = 3'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_in_exec", 16'(state_dbg), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", 16'(state_dbg), 16'd0);
    check("abort_acc_flags", {bus.acc, bus.flags}, 16'h0000);
    check("abort_alu_ab", {bus.ALU_A, bus.ALU_B}, 16'h0000);
    check("abort_alu_sel", 16'(bus.ALU_Select), 16'd0);
    saw_done = bus.done;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 16'(saw_done), 16'd0);
    // B was cleared by reset, so A + B leaves A unchanged.
    load(3'd7, 8'h03);
    issue("post_rst_b", 4'd0, 3'd0, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);

    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Sequencing stage directly upstream and downstream of the 8-bit combinational ALU. It accepts one ALU operation request per handshake and holds the Z80-style register file (B,C,D,E,H,L,A). It drives registered operands and select into the ALU, captures the ALU result, computes the Z80 F flags, and writes the result back to A. The decoder sits upstream; the accumulator and flags are exported for observation.

Parameters:
DATA_W, 8, datapath width; only 8 is supported.
OP_W, 4, width of the op / ALU select field.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  operation request valid.
req_ready  out  1  block can accept a request.
req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP; 6-15 are illegal.
req_src  in  3  operand-B source: 000 B, 001 C, 010 D, 011 E, 100 H, 101 L, 110 req_imm, 111 A.
req_imm  in  8  immediate operand, used when req_src=110.
ld_valid  in  1  direct register load strobe.
ld_idx  in  3  register to load (same encoding as req_src; 110 is ignored).
ld_data  in  8  register load data.
ALU_Select  out  4  to the ALU select input.
ALU_A  out  8  to ALU operand A (always the accumulator).
ALU_B  out  8  to ALU operand B.
ALU_Out  in  8  ALU result (combinational from ALU_Select/ALU_A/ALU_B).
acc  out  8  current A register.
flags  out  8  current F register: [7]S [6]Z [5]0 [4]H [3]0 [2]P/V [1]N [0]C.
done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. All registers B..A, F, ALU_Select, ALU_A, ALU_B and done are cleared to 0. Reset overrides every other event, including mid-operation; no done pulse is issued for the aborted operation.
- State machine has three states:
  - IDLE: req_ready=1. On req_valid, the request is accepted and the state goes to EXEC.
  - EXEC: req_ready=0. The state goes to DONE.
  - DONE: req_ready=0, done=1. The state goes to IDLE.
- Handshake and timing:
  - Acceptance happens at edge N. ALU_Select=req_op (CMP drives 4'b0001), ALU_A=A and ALU_B=selected source are registered at that same edge.
  - The ALU result is valid during EXEC and is captured at the end of EXEC.
  - acc, flags and done update in cycle N+2.
  - Throughput is one operation per 3 cycles.
- Operand sampling: operands are sampled at the acceptance edge. A ld_valid in the same cycle does not affect the operands of that request.
- Operand and select hold: ALU_A, ALU_B and ALU_Select hold their values until the next acceptance.
- Writeback: ADD/SUB/AND/OR/XOR write ALU_Out to A. CMP writes only F. An illegal op writes nothing, leaves F unchanged, and still pulses done.
- Flags: R=ALU_Out, a=ALU_A, b=ALU_B. Bits 5 and 3 are always 0.
  - S=R[7]; Z=(R==0).
  - ADD: H = (a[3:0]+b[3:0]) > 15; V = (a7==b7)&&(R7!=a7); C = 9-bit carry of a+b; N=0.
  - SUB/CMP: H = a[3:0] < b[3:0]; V = (a7!=b7)&&(R7!=a7); C = (a < b) unsigned; N=1.
  - AND: H=1, P = even parity of R, N=0, C=0.
  - OR/XOR: H=0, P = even parity of R, N=0, C=0.
- Register loads: ld_valid is honoured in any state. If a load targets A in the same cycle as an A writeback, the writeback wins. ld_idx=110 is a no-op.
- Other inputs: req_valid outside IDLE is ignored and no request is queued.

Test Plan:
1. Load A=0x7F, B=0x01; ADD src=000 -> done 2 cycles after acceptance, acc=0x80, flags=0x94 (S,H,V).
2. A=0x00; SUB imm 0x01 -> acc=0xFF, flags=0x93 (S,H,N,C). Then A=0x10; CMP imm 0x10 -> acc stays 0x10, flags=0x42 (Z,N).
3. A=0xF0; AND imm 0x3C -> acc=0x30, flags=0x14 (H,P). Then XOR src=111 -> acc=0x00, flags=0x44 (Z,P).
4. req_valid held high with two back-to-back ADDs -> req_ready low in EXEC/DONE, second request accepted exactly 3 cycles after the first, two done pulses 3 cycles apart.
5. Reset asserted during EXEC of ADD with A=0x05 -> next cycle state IDLE, acc=0x00, flags=0x00, ALU_* outputs 0, no done pulse.
6. Illegal op 4'b1001 with A=0x22, F=0x42 -> done pulses, acc=0x22, flags=0x42. Separately, ld_valid to idx 111 with 0x55 coincident with ADD writeback of 0x80 -> acc=0x80.
